// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the RV32I pipeline sequencer: opcodes, FSM states
// and the per-opcode source-register usage lookup.
package riscv_ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } ctrl_state_e;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            R_TYPE, STORE, BRANCH, I_TYPE, LOAD: uses_rs1 = 1'b1;
            default:                             uses_rs1 = 1'b0;
        endcase
    endfunction

    // Only formats with a second register operand; I-type imm bits alias rs2.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            R_TYPE, STORE, BRANCH: uses_rs2 = 1'b1;
            default:               uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// register being loaded by the instruction currently in EX.
module hazard_detect
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = uses_rs1(id_opcode) && (ex_rd == id_rs1);
        rs2_hit  = uses_rs2(id_opcode) && (ex_rd == id_rs2);
        load_use = ex_memread && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: stage enables/flushes, PC select, stall and memory-timeout trap.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int PERF_W      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    input  logic       ex_branch_taken,
    input  logic       mem_memread,
    input  logic       mem_memwrite,
    input  logic       dmem_ready,
    output logic       pc_we,
    output logic       pc_src,
    output logic       if_id_we,
    output logic       if_id_flush,
    output logic       id_ex_we,
    output logic       id_ex_flush,
    output logic       ex_mem_we,
    output logic       mem_wb_flush,
    output logic       stall,
    output logic       mem_error
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    if (PERF_W < 1 || MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_param
        $error("hazard_stall_ctrl: PERF_W must be >= 1 and MEM_TIMEOUT within 2..255");
    end

    ctrl_state_e state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_error_q, mem_error_d;

    logic load_use;
    logic mem_req;
    logic freeze;
    logic run_eval;

    hazard_detect u_hazard_detect (
        .id_opcode  (id_opcode),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_rd      (ex_rd),
        .ex_memread (ex_memread),
        .load_use   (load_use)
    );

    assign mem_req = mem_memread | mem_memwrite;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_error_d  = mem_error_q;
        freeze       = 1'b0;
        run_eval     = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_we     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_we    = 1'b0;
        mem_wb_flush = 1'b0;
        stall        = 1'b0;

        case (state_q)
            ST_INIT: begin
                stall   = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mem_req && !dmem_ready) begin
                    freeze     = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    run_eval = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // Completion is tested first so it wins over a same-cycle timeout.
                if (dmem_ready) begin
                    run_eval   = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d     = ST_ERROR;
                        mem_error_d = 1'b1;
                    end else if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                freeze = 1'b1;
            end
        endcase

        if (freeze) begin
            mem_wb_flush = 1'b1;
            stall        = 1'b1;
        end

        if (run_eval) begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            if (ex_branch_taken) begin
                pc_src      = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_we       = 1'b0;
                if_id_we    = 1'b0;
                id_ex_flush = 1'b1;
                stall       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            wait_cnt_q  <= 8'd0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign mem_error = mem_error_q;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    logic [PERF_W-1:0] perf_stall_cnt_q, perf_stall_cnt_d;
    logic [PERF_W-1:0] perf_flush_cnt_q, perf_flush_cnt_d;

    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        perf_flush_cnt_d = perf_flush_cnt_q;
        if (stall && (state_q != ST_INIT)) begin
            perf_stall_cnt_d = perf_stall_cnt_q + PERF_ONE;
        end
        if (pc_src) begin
            perf_flush_cnt_d = perf_flush_cnt_q + PERF_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; control vector order is
// {pc_we, pc_src, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush, stall}.
module tb_hazard_stall_ctrl;
    import riscv_ctrl_pkg::*;

    localparam int MEM_TIMEOUT = 16;
    localparam int PERF_W      = 32;

    localparam logic [8:0] C_INIT   = 9'b000000001;
    localparam logic [8:0] C_NORMAL = 9'b101010100;
    localparam logic [8:0] C_LDUSE  = 9'b000011101;
    localparam logic [8:0] C_BRANCH = 9'b111111100;
    localparam logic [8:0] C_FREEZE = 9'b000000011;

    logic       clk;
    logic       rst_n;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic       ex_memread;
    logic       ex_branch_taken;
    logic       mem_memread;
    logic       mem_memwrite;
    logic       dmem_ready;
    logic       pc_we, pc_src, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
    logic       ex_mem_we, mem_wb_flush, stall, mem_error;
`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] perf_stall_cnt;
    logic [PERF_W-1:0] perf_flush_cnt;
`endif

    logic [8:0] ctl;
    assign ctl = {pc_we, pc_src, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
                  ex_mem_we, mem_wb_flush, stall};

    int checks   = 0;
    int failures = 0;

    hazard_stall_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .PERF_W      (PERF_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_opcode       (id_opcode),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_memread     (mem_memread),
        .mem_memwrite    (mem_memwrite),
        .dmem_ready      (dmem_ready),
        .pc_we           (pc_we),
        .pc_src          (pc_src),
        .if_id_we        (if_id_we),
        .if_id_flush     (if_id_flush),
        .id_ex_we        (id_ex_we),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_we       (ex_mem_we),
        .mem_wb_flush    (mem_wb_flush),
        .stall           (stall),
        .mem_error       (mem_error)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        id_opcode       = I_TYPE;
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        ex_rd           = 5'd0;
        ex_memread      = 1'b0;
        ex_branch_taken = 1'b0;
        mem_memread     = 1'b0;
        mem_memwrite    = 1'b0;
        dmem_ready      = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        adv();
        adv();

        settle();
        chk("reset_ctl", 32'(ctl), 32'(C_INIT));
        chk("reset_err", 32'(mem_error), 32'd0);

        rst_n = 1'b1;
        settle();
        chk("init_cycle", 32'(ctl), 32'(C_INIT));
        adv();
        settle();
        chk("first_run", 32'(ctl), 32'(C_NORMAL));
        chk("first_run_err", 32'(mem_error), 32'd0);

        // lw x5 in EX, add x6,x5,x1 in ID
        adv();
        ex_memread = 1'b1; ex_rd = 5'd5;
        id_opcode = R_TYPE; id_rs1 = 5'd5; id_rs2 = 5'd1;
        settle();
        chk("loaduse_rs1", 32'(ctl), 32'(C_LDUSE));
        adv();
        ex_memread = 1'b0; ex_rd = 5'd6;
        settle();
        chk("after_bubble", 32'(ctl), 32'(C_NORMAL));

        // addi x6,x7,1 whose imm bits alias x5 in the rs2 field
        adv();
        ex_memread = 1'b1; ex_rd = 5'd5;
        id_opcode = I_TYPE; id_rs1 = 5'd7; id_rs2 = 5'd5;
        settle();
        chk("itype_no_dep", 32'(ctl), 32'(C_NORMAL));

        adv();
        ex_rd = 5'd0; id_opcode = R_TYPE; id_rs1 = 5'd0; id_rs2 = 5'd0;
        settle();
        chk("x0_no_stall", 32'(ctl), 32'(C_NORMAL));

        adv();
        ex_rd = 5'd9; id_opcode = LUI; id_rs1 = 5'd9; id_rs2 = 5'd9;
        settle();
        chk("lui_no_stall", 32'(ctl), 32'(C_NORMAL));

        // branch taken together with a live load-use hazard
        adv();
        ex_rd = 5'd5; id_opcode = R_TYPE; id_rs1 = 5'd1; id_rs2 = 5'd5;
        ex_branch_taken = 1'b1;
        settle();
        chk("branch_over_lduse", 32'(ctl), 32'(C_BRANCH));

        // store in MEM, three cycles without dmem_ready; a taken branch is suppressed
        adv();
        idle_inputs();
        mem_memwrite = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        settle();
        chk("wait_freeze_0", 32'(ctl), 32'(C_FREEZE));
        for (int i = 1; i < 3; i++) begin
            adv();
            settle();
            chk($sformatf("wait_freeze_%0d", i), 32'(ctl), 32'(C_FREEZE));
        end
        adv();
        dmem_ready = 1'b1;
        settle();
        chk("wait_release", 32'(ctl), 32'(C_BRANCH));
        chk("wait_release_err", 32'(mem_error), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", perf_stall_cnt, 32'd4);
        chk("perf_flush", perf_flush_cnt, 32'd1);
`endif
        adv();
        idle_inputs();
        settle();
        chk("post_wait_run", 32'(ctl), 32'(C_NORMAL));

        // timeout: sixteen frozen cycles, then ERROR
        adv();
        mem_memread = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            if (i != 0) adv();
            settle();
            chk($sformatf("to_freeze_%0d", i), 32'(ctl), 32'(C_FREEZE));
            chk($sformatf("to_err_low_%0d", i), 32'(mem_error), 32'd0);
        end
        adv();
        settle();
        chk("error_ctl", 32'(ctl), 32'(C_FREEZE));
        chk("error_flag", 32'(mem_error), 32'd1);
        dmem_ready = 1'b1;
        adv();
        settle();
        chk("error_sticky_ctl", 32'(ctl), 32'(C_FREEZE));
        chk("error_sticky_flag", 32'(mem_error), 32'd1);

        rst_n = 1'b0;
        settle();
        chk("error_reset_ctl", 32'(ctl), 32'(C_INIT));
        chk("error_reset_flag", 32'(mem_error), 32'd0);
        adv();
        idle_inputs();
        rst_n = 1'b1;
        adv();
        settle();
        chk("rerun", 32'(ctl), 32'(C_NORMAL));

        // completion in the would-be timeout cycle wins
        adv();
        mem_memread = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
            if (i != 0) adv();
            settle();
            chk($sformatf("race_freeze_%0d", i), 32'(ctl), 32'(C_FREEZE));
        end
        adv();
        dmem_ready = 1'b1;
        settle();
        chk("race_release", 32'(ctl), 32'(C_NORMAL));
        adv();
        idle_inputs();
        settle();
        chk("race_no_err", 32'(mem_error), 32'd0);
        chk("race_run", 32'(ctl), 32'(C_NORMAL));

        // reset asserted in the middle of a memory wait
        adv();
        mem_memwrite = 1'b1; dmem_ready = 1'b0;
        adv();
        adv();
        settle();
        chk("midwait_freeze", 32'(ctl), 32'(C_FREEZE));
        rst_n = 1'b0;
        settle();
        chk("midwait_reset_ctl", 32'(ctl), 32'(C_INIT));
        chk("midwait_reset_err", 32'(mem_error), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall_clr", perf_stall_cnt, 32'd0);
        chk("perf_flush_clr", perf_flush_cnt, 32'd0);
`endif
        adv();
        idle_inputs();
        rst_n = 1'b1;
        settle();
        chk("midwait_init", 32'(ctl), 32'(C_INIT));
        adv();
        settle();
        chk("midwait_run", 32'(ctl), 32'(C_NORMAL));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV32I core; sits beside the main opcode decoder.
- Generates per-stage write-enable and flush controls, the PC source select and a stall indicator.
- Covers three hazard sources: load-use hazards (one bubble), taken branches (flush IF/ID and ID/EX), and variable-latency data-memory accesses (freeze until the memory handshake completes, with a timeout).

Parameters:
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before the error trap; legal range 2..255.
- PERF_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_opcode  in  7  opcode of the instruction in ID
- id_rs1  in  5  rs1 field of the instruction in ID
- id_rs2  in  5  rs2 field of the instruction in ID
- ex_rd  in  5  destination register of the instruction in EX
- ex_memread  in  1  instruction in EX is a load
- ex_branch_taken  in  1  EX branch resolved taken (Branch AND condition)
- mem_memread  in  1  instruction in MEM is a load
- mem_memwrite  in  1  instruction in MEM is a store
- dmem_ready  in  1  data memory has completed the current access
- pc_we  out  1  PC register write enable
- pc_src  out  1  0: PC+4; 1: branch target
- if_id_we  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID load NOP
- id_ex_we  out  1  ID/EX write enable
- id_ex_flush  out  1  ID/EX load bubble (all control bits 0)
- ex_mem_we  out  1  EX/MEM write enable
- mem_wb_flush  out  1  MEM/WB load bubble
- stall  out  1  pipeline frozen this cycle
- mem_error  out  1  sticky memory timeout flag

Behaviour:
- FSM states: INIT, RUN, MEM_WAIT, ERROR. Reset forces INIT, wait_cnt=0, mem_error=0.
- Outputs are a Mealy function of state and inputs. Only state, wait_cnt and mem_error are registered.
- INIT:
  - All write enables 0, all flushes 0, pc_src=0, stall=1.
  - Goes to RUN on the first clock after rst_n deasserts (one-cycle start latency).
- RUN, mem_req = mem_memread | mem_memwrite:
  - Priority 1, mem_req & !dmem_ready: freeze. pc_we=if_id_we=id_ex_we=ex_mem_we=0, mem_wb_flush=1, stall=1. Next state MEM_WAIT, wait_cnt=1. Branch and load-use outputs are suppressed; their inputs are held by the frozen registers and re-evaluated later.
  - Priority 2, ex_branch_taken: pc_src=1, if_id_flush=1, id_ex_flush=1. All enables 1. This overrides load-use.
  - Priority 3, load-use: ex_memread & ex_rd!=0 & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)). Then pc_we=0, if_id_we=0, id_ex_flush=1, stall=1; id_ex_we and ex_mem_we stay 1.
  - Otherwise all enables 1, flushes 0, pc_src=0, stall=0.
- Register usage by opcode:
  - R-type, store, branch: rs1 and rs2.
  - I-type ALU, load: rs1 only.
  - LUI and unknown opcodes: neither.
- MEM_WAIT:
  - Freeze outputs as in RUN priority 1.
  - dmem_ready=1: this cycle's outputs switch to the RUN evaluation (normal advance, branch/load-use rules apply). Next state RUN, wait_cnt=0.
  - dmem_ready=0 and wait_cnt==MEM_TIMEOUT-1: next state ERROR, mem_error set.
  - Otherwise wait_cnt increments (8-bit, saturating).
- ERROR: freeze as MEM_WAIT with mem_error=1; only rst_n exits.
- Simultaneous events:
  - dmem_ready arriving in the same cycle as the timeout: completion wins.
  - rst_n asserted mid-wait: immediate return to INIT; counters and the flag are cleared.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cnt[PERF_W] (+1 per cycle with stall=1 outside INIT) and perf_flush_cnt[PERF_W] (+1 per taken-branch flush).
  - Both wrap at 2^PERF_W and reset to 0.
- Undefined: neither port nor counter logic exists.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants (R_TYPE 0110011, I_TYPE 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111);
  - the FSM state enum;
  - the uses_rs1/uses_rs2 lookup function.
- Sub-module hazard_detect: purely combinational load-use comparator; the FSM and counters stay in the top.

Test Plan:
- Reset then release → one INIT cycle with stall=1 and all enables 0; next cycle pc_we=1, stall=0.
- EX = lw x5, ID = add x6,x5,x1 → one cycle pc_we=0, if_id_we=0, id_ex_flush=1; ID = addi x6,x7,1 (no dependency) → no stall; ex_rd=x0 → no stall.
- ex_branch_taken=1 with load-use also true → pc_src=1, if_id_flush=1, id_ex_flush=1, pc_we=1.
- Store in MEM with dmem_ready low for 3 cycles → 3 frozen cycles with mem_wb_flush=1, release on the 4th, mem_error=0.
- dmem_ready held low with MEM_TIMEOUT=16 → ERROR entered after 16 frozen cycles with mem_error=1 held; rst_n pulse clears it.
- With HAZARD_PERF_CNT_EN: the two scenarios above give perf_stall_cnt=4 (1 load-use + 3 wait) and perf_flush_cnt=1.
